bcd_to_binary: RTL

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

---
 rtl/bcd_to_binary_if.sv | 23 ++
 rtl/bcd_to_binary.sv | 90 +++++++++
 2 files changed

// File: rtl/bcd_to_binary_if.sv
// BCD-to-binary converter bus: start request, four BCD digits, and the
// registered result/status returned by the converter.
interface bcd_to_binary_if;
  logic        start;
  logic [3:0]  thos;
  logic [3:0]  huns;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [13:0] binary;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, thos, huns, tens, ones,
    input  binary, busy, done, err
  );

  modport slave (
    input  start, thos, huns, tens, ones,
    output binary, busy, done, err
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Serial 4-digit BCD to 14-bit binary converter (acc = acc*10 + digit,
// thousands first). One conversion takes 4 accumulate cycles plus a
// one-cycle FIN state in which a new start is accepted back-to-back.
// Optional macro BCD_RANGE_CHECK_EN: flags digits > 9 via err and forces
// binary to 0 for that conversion; when undefined err is tied low.
module bcd_to_binary (
  input  logic           clk,
  input  logic           reset,
  bcd_to_binary_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state;
  logic [15:0] digits;
  logic [13:0] acc;
  logic [1:0]  cnt;
  logic [13:0] acc_next;

  // acc*10 as (acc<<3)+(acc<<1), wrapping at 14 bits
  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, digits[15:12]};

`ifdef BCD_RANGE_CHECK_EN
  logic bad_digit;
  logic bad_in;

  assign bad_in = (bus.thos > 4'd9) || (bus.huns > 4'd9) ||
                  (bus.tens > 4'd9) || (bus.ones > 4'd9);

  // sticky invalid-digit flag, captured with the digits; err reports it at completion
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_digit <= 1'b0;
      bus.err   <= 1'b0;
    end else if (state != ACC && bus.start) begin
      bad_digit <= bad_in;
      bus.err   <= 1'b0;
    end else if (state == ACC && cnt == 2'd3) begin
      bus.err   <= bad_digit;
    end
  end
`else
  logic bad_digit;
  assign bad_digit = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // conversion FSM, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      digits     <= '0;
      acc        <= '0;
      cnt        <= '0;
      bus.binary <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (bus.start) begin
            state    <= ACC;
            digits   <= {bus.thos, bus.huns, bus.tens, bus.ones};
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ACC: begin
          acc    <= acc_next;
          digits <= {digits[11:0], 4'h0};
          cnt    <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state      <= FIN;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.binary <= bad_digit ? 14'd0 : acc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
